knn_vote: RTL

- Downstream consumer of the pipeline sorter in the kNN accelerator.
- After the sorter holds the final K nearest neighbours, this block walks the sorter's SEL read port over entries 0..k-1 and collects the returned neighbour labels.
- It tallies one vote per class and reports the majority class and its vote count to the CPU-side register interface.

---
 rtl/knn_vote_if.sv | 39 +++
 rtl/knn_vote.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/knn_vote_if.sv
// ---------------------------------------------------------------------------
// knn_vote_if
// Bundles the signals between the kNN vote block, the CPU-side register
// interface and the sorter read port.
//   start     : one-cycle request to begin a vote            (master -> slave)
//   k         : neighbours to use for this vote               (master -> slave)
//   label_in  : label returned by the sorter DATA_OUT         (master -> slave)
//   sel       : index driven to the sorter SEL input          (slave -> master)
//   busy      : vote in progress                              (slave -> master)
//   done      : one-cycle pulse when the result is updated    (slave -> master)
//   res_valid : result registers hold a valid vote            (slave -> master)
//   class_out : winning class                                 (slave -> master)
//   votes_out : vote count of the winning class               (slave -> master)
// The vote block is the slave; the CPU/sorter side is the master.
// ---------------------------------------------------------------------------
interface knn_vote_if #(
   parameter int LABEL_W = 8,
   parameter int CNT_W   = 8
);
   logic               start;
   logic [7:0]         k;
   logic [15:0]        sel;
   logic [LABEL_W-1:0] label_in;
   logic               busy;
   logic               done;
   logic               res_valid;
   logic [LABEL_W-1:0] class_out;
   logic [CNT_W-1:0]   votes_out;

   modport slave (
      input  start, k, label_in,
      output sel, busy, done, res_valid, class_out, votes_out
   );

   modport master (
      output start, k, label_in,
      input  sel, busy, done, res_valid, class_out, votes_out
   );
endinterface

// File: rtl/knn_vote.sv
// ---------------------------------------------------------------------------
// knn_vote
// Majority vote over the K nearest neighbours held by the pipeline sorter.
// On start it walks the sorter SEL port over entries 0..keff-1, tallies one
// vote per returned label (labels >= N_CLASSES are ignored), scans the
// tallies for the largest count (ties go to the lowest class) and publishes
// the winner with a one-cycle done pulse.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous active-low reset
//   bus  : knn_vote_if.slave (start/k/label_in in; sel/busy/done/res_valid/
//          class_out/votes_out out)
// Sequence: IDLE -> CLEAR -> READ (keff cycles) -> DRAIN (RD_LAT cycles)
//           -> SCAN (N_CLASSES cycles) -> FIN -> IDLE
// ---------------------------------------------------------------------------
module knn_vote #(
   parameter int HW_K      = 10,
   parameter int LABEL_W   = 8,
   parameter int N_CLASSES = 16,
   parameter int RD_LAT    = 1,
   parameter int CNT_W     = 8
) (
   input  logic       clk,
   input  logic       rst,
   knn_vote_if.slave  bus
);

   localparam int SCAN_W  = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1;
   localparam int DRAIN_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(N_CLASSES - 1);
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = (RD_LAT > 0) ? DRAIN_W'(RD_LAT - 1) : '0;
   localparam logic [15:0]        HW_K_16    = 16'(HW_K);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_READ,
      S_DRAIN,
      S_SCAN,
      S_FIN
   } state_t;

   state_t               state_q;
   logic [15:0]          keff_q;
   logic [15:0]          sel_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 res_valid_q;
   logic [LABEL_W-1:0]   class_q;
   logic [CNT_W-1:0]     votes_q;
   logic [DRAIN_W-1:0]   drain_q;
   logic [SCAN_W-1:0]    scan_idx_q;
   logic [SCAN_W-1:0]    best_cls_q;
   logic [CNT_W-1:0]     best_votes_q;

   logic [15:0]          keff_d;
   logic [SCAN_W-1:0]    best_cls_d;
   logic [CNT_W-1:0]     best_votes_d;

   logic                 issue;
   logic                 label_vld;
   logic                 clr_cnt;
   logic [N_CLASSES-1:0][CNT_W-1:0] cnt_all;

   // ------------------------------------------------------------------------
   // Effective neighbour count: 0 behaves as 1, anything above the sorter
   // depth is clamped to the depth.
   // ------------------------------------------------------------------------
   always_comb begin
      keff_d = 16'(bus.k);
      if (bus.k == 8'd0) begin
         keff_d = 16'd1;
      end else if (16'(bus.k) > HW_K_16) begin
         keff_d = HW_K_16;
      end
   end

   assign issue   = (state_q == S_READ);
   assign clr_cnt = (state_q == S_CLEAR);

   // ------------------------------------------------------------------------
   // Issue tag pipe: one bit per READ cycle, delayed by the sorter read
   // latency so the tag lines up with the label it belongs to.
   // ------------------------------------------------------------------------
   generate
      if (RD_LAT == 0) begin : g_no_lat
         assign label_vld = issue;
      end else begin : g_lat
         logic [RD_LAT-1:0] pipe_q;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               pipe_q <= '0;
            end else begin
               // shift left, oldest tag falls off the top
               pipe_q <= RD_LAT'({pipe_q, issue});
            end
         end

         assign label_vld = pipe_q[RD_LAT-1];
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Vote counters, one per class. A label equal to the class index bumps
   // that counter; labels >= N_CLASSES match no counter and are dropped.
   // keff <= HW_K < 2^CNT_W, so the counters never wrap.
   // ------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < N_CLASSES; gi++) begin : g_cnt
         logic [CNT_W-1:0] cnt_q;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               cnt_q <= '0;
            end else if (clr_cnt) begin
               cnt_q <= '0;
            end else if (label_vld && (bus.label_in == LABEL_W'(gi))) begin
               cnt_q <= cnt_q + 1'b1;
            end
         end

         assign cnt_all[gi] = cnt_q;
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Running best: replace only on a strictly greater count so that equal
   // counts keep the earlier (lower) class index.
   // ------------------------------------------------------------------------
   always_comb begin
      best_cls_d   = best_cls_q;
      best_votes_d = best_votes_q;
      if (cnt_all[scan_idx_q] > best_votes_q) begin
         best_cls_d   = scan_idx_q;
         best_votes_d = cnt_all[scan_idx_q];
      end
   end

   // ------------------------------------------------------------------------
   // Control FSM with registered outputs.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         keff_q       <= 16'd1;
         sel_q        <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         res_valid_q  <= 1'b0;
         class_q      <= '0;
         votes_q      <= '0;
         drain_q      <= '0;
         scan_idx_q   <= '0;
         best_cls_q   <= '0;
         best_votes_q <= '0;
      end else begin
         done_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  keff_q      <= keff_d;
                  busy_q      <= 1'b1;
                  res_valid_q <= 1'b0;
                  state_q     <= S_CLEAR;
               end
            end

            S_CLEAR: begin
               // counters are cleared by their own blocks in this cycle
               sel_q        <= '0;
               drain_q      <= '0;
               scan_idx_q   <= '0;
               best_cls_q   <= '0;
               best_votes_q <= '0;
               state_q      <= S_READ;
            end

            S_READ: begin
               if (sel_q == keff_q - 16'd1) begin
                  sel_q   <= '0;
                  // with zero read latency the last label is already counted
                  state_q <= (RD_LAT == 0) ? S_SCAN : S_DRAIN;
               end else begin
                  sel_q <= sel_q + 16'd1;
               end
            end

            S_DRAIN: begin
               if (drain_q == DRAIN_LAST) begin
                  state_q <= S_SCAN;
               end else begin
                  drain_q <= drain_q + 1'b1;
               end
            end

            S_SCAN: begin
               best_cls_q   <= best_cls_d;
               best_votes_q <= best_votes_d;
               if (scan_idx_q == SCAN_LAST) begin
                  // results become visible together with the done pulse
                  class_q     <= LABEL_W'(best_cls_d);
                  votes_q     <= best_votes_d;
                  done_q      <= 1'b1;
                  res_valid_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= S_FIN;
               end else begin
                  scan_idx_q <= scan_idx_q + 1'b1;
               end
            end

            S_FIN: begin
               // start is still ignored here; IDLE accepts it next cycle
               state_q <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.sel       = sel_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.res_valid = res_valid_q;
   assign bus.class_out = class_q;
   assign bus.votes_out = votes_q;

endmodule
